// File: rtl/aes_share_sched_if.sv
// Bundle between the requester, the share scheduler and the single AES core.
// Handshakes:
//   requester -> scheduler: start is a request qualified only while the
//     scheduler is idle (busy=0); a start seen while busy=1 is dropped, never
//     queued. done is a one-cycle completion pulse; res_msb/res_lsb are valid
//     in that cycle and held until the next accepted start.
//   scheduler -> core: aes_enable is a one-cycle issue pulse. aes_word,
//     aes_key and aes_mode stay stable until the core answers. aes_done
//     (with aes_result) is the completion; a level held across several cycles
//     counts once.
interface aes_share_sched_if #(
  parameter int TXT_BW = 128,
  parameter int KEY_BW = 256
);
  logic              start;
  logic              mode;
  logic [KEY_BW-1:0] key;
  logic [TXT_BW-1:0] txt_msb;
  logic [TXT_BW-1:0] txt_lsb;
  logic              busy;
  logic              aes_enable;
  logic              aes_mode;
  logic [KEY_BW-1:0] aes_key;
  logic [TXT_BW-1:0] aes_word;
  logic [TXT_BW-1:0] aes_result;
  logic              aes_done;
  logic [TXT_BW-1:0] res_msb;
  logic [TXT_BW-1:0] res_lsb;
  logic              done;
  logic              err;

  // Requester plus AES core side.
  modport master (
    output start, mode, key, txt_msb, txt_lsb, aes_result, aes_done,
    input  busy, aes_enable, aes_mode, aes_key, aes_word, res_msb, res_lsb,
           done, err
  );

  // Scheduler side.
  modport slave (
    input  start, mode, key, txt_msb, txt_lsb, aes_result, aes_done,
    output busy, aes_enable, aes_mode, aes_key, aes_word, res_msb, res_lsb,
           done, err
  );
endinterface

// File: rtl/aes_share_sched.sv
// aes_share_sched: shares one AES core between the MSB and LSB 128-bit halves
// of a 256-bit digest. A job is captured on start, the MSB half is issued,
// then the LSB half, and one done pulse reports both results.
// Optional feature macro: AES_SCHED_TIMEOUT_EN adds a per-half watchdog that
// raises a sticky err and finishes the job when the core does not answer.
// dbg_state exposes the FSM state; IDLE reads as 0.
module aes_share_sched #(
  parameter int TXT_BW = 128,
  parameter int KEY_BW = 256,
  parameter int TO_CYC = 64
) (
  input  logic               clk,
  input  logic               srst,
  aes_share_sched_if.slave   bus,
  output logic [2:0]         dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISS_M  = 3'd1;
  localparam logic [2:0] WAIT_M = 3'd2;
  localparam logic [2:0] ISS_L  = 3'd3;
  localparam logic [2:0] WAIT_L = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  // The watchdog counter is 7 bits wide.
  if (TO_CYC < 1 || TO_CYC > 128) begin : g_to_cyc_range
    $error("aes_share_sched: TO_CYC must be in 1..128");
  end

  logic [2:0]        state;
  logic              mode_q;
  logic [KEY_BW-1:0] key_q;
  logic [TXT_BW-1:0] word_q;
  logic [TXT_BW-1:0] lsb_q;
  logic [TXT_BW-1:0] res_msb_q;
  logic [TXT_BW-1:0] res_lsb_q;
  logic              done_q;
  logic              done_take;
  logic              in_wait;
  logic              wd_hit;

  // A completion is the first cycle of an aes_done level: a level still high
  // from the previous half (or a held pulse) must not be taken twice.
  assign done_take = bus.aes_done & ~done_q;
  assign in_wait   = (state == WAIT_M) || (state == WAIT_L);

`ifdef AES_SCHED_TIMEOUT_EN
  logic [6:0] wd_cnt;
  logic       err_q;

  // Watchdog count of wait cycles; zeroed while issuing so each half starts fresh.
  always_ff @(posedge clk) begin
    if (srst) begin
      wd_cnt <= '0;
    end else if (state == ISS_M || state == ISS_L) begin
      wd_cnt <= '0;
    end else if (in_wait) begin
      wd_cnt <= wd_cnt + 7'd1;
    end
  end

  assign wd_hit = in_wait && !done_take && (wd_cnt == 7'(TO_CYC - 1));

  // Sticky timeout flag, cleared by reset or by the next accepted job.
  always_ff @(posedge clk) begin
    if (srst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      err_q <= 1'b0;
    end else if (wd_hit) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign wd_hit  = 1'b0;
  assign bus.err = 1'b0;
`endif

  // Job FSM plus the captured job and result registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
      key_q     <= '0;
      word_q    <= '0;
      lsb_q     <= '0;
      res_msb_q <= '0;
      res_lsb_q <= '0;
    end else begin
      done_q <= bus.aes_done;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q    <= bus.mode;
            key_q     <= bus.key;
            word_q    <= bus.txt_msb;
            lsb_q     <= bus.txt_lsb;
            res_msb_q <= '0;
            res_lsb_q <= '0;
            state     <= ISS_M;
          end
        end
        ISS_M: state <= WAIT_M;
        WAIT_M: begin
          if (done_take) begin
            res_msb_q <= bus.aes_result;
            word_q    <= lsb_q;
            state     <= ISS_L;
          end else if (wd_hit) begin
            state <= FIN;
          end
        end
        ISS_L: state <= WAIT_L;
        WAIT_L: begin
          if (done_take) begin
            res_lsb_q <= bus.aes_result;
            state     <= FIN;
          end else if (wd_hit) begin
            state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the registered state; issued values come only from captures.
  assign bus.aes_enable = (state == ISS_M) || (state == ISS_L);
  assign bus.done       = (state == FIN);
  assign bus.busy       = (state != IDLE);
  assign bus.aes_mode   = mode_q;
  assign bus.aes_key    = key_q;
  assign bus.aes_word   = word_q;
  assign bus.res_msb    = res_msb_q;
  assign bus.res_lsb    = res_lsb_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_aes_share_sched.sv
// Bench for aes_share_sched: a cycle-stepped AES core model answers issues
// with a reference function; jobs are checked for issue timing, issued
// values, done latency, results, and the boundary behaviours.
module tb_aes_share_sched;
  localparam int TXT_BW = 128;
  localparam int KEY_BW = 256;
  localparam int TO_CYC = 64;

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- clock / reset ----------------
  logic       clk  = 1'b0;
  logic       srst = 1'b1;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  aes_share_sched_if #(.TXT_BW(TXT_BW), .KEY_BW(KEY_BW)) bus ();

  aes_share_sched #(.TXT_BW(TXT_BW), .KEY_BW(KEY_BW), .TO_CYC(TO_CYC)) dut (
    .clk       (clk),
    .srst      (srst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [255:0] exp_q[$];
  logic [255:0] last_exp = '0;

  // core model state
  int           core_wait = 0;
  int           core_hold_left = 0;
  int           core_dly = 14;
  int           core_hold = 1;
  logic         core_mute = 1'b0;
  logic         spur = 1'b0;
  logic [127:0] core_res = '0;

  // current job
  int           acc_cyc = 0;
  int           en_count = 0;
  int           exp_lat = 0;
  int           exp_en = 0;
  logic         exp_err = 1'b0;
  logic         cur_mode = 1'b0;
  logic [255:0] cur_key = '0;
  logic [127:0] cur_msb = '0;
  logic [127:0] cur_lsb = '0;
  logic         in_job = 1'b0;
  logic         done_seen = 1'b0;
  logic         in_reset = 1'b1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Stand-in for AES: known FIPS-197 AES-256 pairs, otherwise a keyed scramble.
  function automatic logic [127:0] aes_ref(input logic m, input logic [255:0] k,
                                           input logic [127:0] w);
    if (k == FIPS_KEY && !m && w == FIPS_PT) return FIPS_CT;
    if (k == FIPS_KEY &&  m && w == FIPS_CT) return FIPS_PT;
    return {w[63:0], w[127:64]} ^ k[255:128] ^ k[127:0] ^ {128{m}};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: monitor the new cycle's outputs, then drive the core model.
  task automatic tick();
    logic [255:0] exp_v;
    @(posedge clk);
    #1;
    cyc++;
    if (!in_reset) begin
      if (bus.aes_enable) begin
        if (!in_job) begin
          check("unexp_enable", 256'(1), 256'(0));
        end else begin
          en_count++;
          check("issue_cycle", 256'(cyc - acc_cyc), 256'(en_count == 1 ? 1 : core_dly + 3));
          check("issue_word", 256'(bus.aes_word), 256'(en_count == 1 ? cur_msb : cur_lsb));
          check("issue_key", bus.aes_key, cur_key);
          check("issue_mode", 256'(bus.aes_mode), 256'(cur_mode));
        end
      end
      if (bus.done) begin
        if (!in_job || exp_q.size() == 0) begin
          check("unexp_done", 256'(1), 256'(0));
        end else begin
          exp_v = exp_q.pop_front();
          check("done_latency", 256'(cyc - acc_cyc), 256'(exp_lat));
          check("res_msb", 256'(bus.res_msb), 256'(exp_v[255:128]));
          check("res_lsb", 256'(bus.res_lsb), 256'(exp_v[127:0]));
          check("done_busy", 256'(bus.busy), 256'(1));
          check("done_issues", 256'(en_count), 256'(exp_en));
          check("done_err", 256'(bus.err), 256'(exp_err));
          in_job    = 1'b0;
          done_seen = 1'b1;
        end
      end
    end
    bus.aes_done = 1'b0;
    if (core_wait > 0) begin
      core_wait--;
      if (core_wait == 0) begin
        core_hold_left = core_hold;
        check("word_stable", 256'(bus.aes_word), 256'(en_count == 1 ? cur_msb : cur_lsb));
      end
    end
    if (core_hold_left > 0) begin
      bus.aes_done   = 1'b1;
      bus.aes_result = core_res;
      core_hold_left--;
    end
    if (spur) begin
      bus.aes_done   = 1'b1;
      bus.aes_result = rand128();
      spur           = 1'b0;
    end
    if (bus.aes_enable && !core_mute && !in_reset) begin
      core_res  = aes_ref(bus.aes_mode, bus.aes_key, bus.aes_word);
      core_wait = core_dly + 1;
    end
  endtask

  task automatic clear_model();
    core_wait      = 0;
    core_hold_left = 0;
    spur           = 1'b0;
    bus.aes_done   = 1'b0;
    exp_q.delete();
    in_job         = 1'b0;
    last_exp       = '0;
  endtask

  task automatic do_reset(input int n);
    srst      = 1'b1;
    in_reset  = 1'b1;
    bus.start = 1'b0;
    repeat (n) tick();
    srst      = 1'b0;
    in_reset  = 1'b0;
    clear_model();
  endtask

  // pokes: [0] start in WAIT_M, [1] start in FIN, [2] spurious done in ISS_L,
  //        [3] srst in WAIT_L (job abandoned)
  task automatic run_job(input logic m, input logic [255:0] k, input logic [127:0] hm,
                         input logic [127:0] hl, input int dly, input int hold,
                         input logic [3:0] pokes, input logic mute);
    int rel;
    cur_mode  = m;
    cur_key   = k;
    cur_msb   = hm;
    cur_lsb   = hl;
    core_dly  = dly;
    core_hold = hold;
    core_mute = mute;
    bus.mode    = m;
    bus.key     = k;
    bus.txt_msb = hm;
    bus.txt_lsb = hl;
    bus.start   = 1'b1;
    check("accept_idle", 256'(dbg_state), 256'(0));
    check("accept_busy", 256'(bus.busy), 256'(0));
    acc_cyc   = cyc;
    en_count  = 0;
    in_job    = 1'b1;
    done_seen = 1'b0;
    exp_en    = mute ? 1 : 2;
    exp_lat   = mute ? TO_CYC + 2 : 5 + 2 * dly;
    exp_err   = mute;
    last_exp  = mute ? 256'(0) : {aes_ref(m, k, hm), aes_ref(m, k, hl)};
    exp_q.push_back(last_exp);
    tick();
    bus.start   = 1'b0;
    bus.mode    = ~m;
    bus.key     = {rand128(), rand128()};
    bus.txt_msb = rand128();
    bus.txt_lsb = rand128();
    check("res_clear", {bus.res_msb, bus.res_lsb}, 256'(0));
    check("busy_after_accept", 256'(bus.busy), 256'(1));
    check("err_clear", 256'(bus.err), 256'(0));
    for (int i = 0; i < 400 && !done_seen; i++) begin
      rel = cyc - acc_cyc;
      bus.start = pokes[0] && rel == 5;
      if (pokes[2] && rel == dly + 2) spur = 1'b1;
      if (pokes[3] && rel == dly + 6) begin
        srst     = 1'b1;
        in_reset = 1'b1;
        tick();
        srst     = 1'b0;
        in_reset = 1'b0;
        check("rst_busy", 256'(bus.busy), 256'(0));
        check("rst_res", {bus.res_msb, bus.res_lsb}, 256'(0));
        check("rst_state", 256'(dbg_state), 256'(0));
        check("rst_outs", {bus.aes_key, 3'(0)} ^ 256'({bus.aes_enable, bus.done, bus.aes_mode}),
              256'(0));
        clear_model();
        return;
      end
      tick();
    end
    bus.start = 1'b0;
    if (!done_seen) begin
      check("done_timeout", 256'(0), 256'(1));
      in_job = 1'b0;
      return;
    end
    if (pokes[1]) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("post_fin_idle", 256'(dbg_state), 256'(0));
    check("post_fin_busy", 256'(bus.busy), 256'(0));
    repeat (3) tick();
    check("res_hold", {bus.res_msb, bus.res_lsb}, last_exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.key        = '0;
    bus.txt_msb    = '0;
    bus.txt_lsb    = '0;
    bus.aes_result = '0;
    bus.aes_done   = 1'b0;

    // T1 reset
    do_reset(2);
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_enable", 256'(bus.aes_enable), 256'(0));
    check("rst_done", 256'(bus.done), 256'(0));
    check("rst_err", 256'(bus.err), 256'(0));
    check("rst_mode", 256'(bus.aes_mode), 256'(0));
    check("rst_key", bus.aes_key, 256'(0));
    check("rst_word", 256'(bus.aes_word), 256'(0));
    check("rst_res", {bus.res_msb, bus.res_lsb}, 256'(0));
    check("rst_state", 256'(dbg_state), 256'(0));

    // T2 FIPS-197 encrypt and decrypt jobs, Dm=Dl=14
    run_job(1'b0, FIPS_KEY, FIPS_PT, FIPS_PT, 14, 1, 4'b0000, 1'b0);
    check("fips_enc", {bus.res_msb, bus.res_lsb}, {FIPS_CT, FIPS_CT});
    run_job(1'b1, FIPS_KEY, FIPS_CT, FIPS_CT, 14, 1, 4'b0000, 1'b0);
    check("fips_dec", {bus.res_msb, bus.res_lsb}, {FIPS_PT, FIPS_PT});

    // T3 start in WAIT_M and in FIN
    run_job(1'b0, {rand128(), rand128()}, rand128(), rand128(), 10, 1, 4'b0011, 1'b0);

    // T4 spurious done in IDLE, in ISS_L, then done held 3 cycles
    spur = 1'b1;
    tick();
    tick();
    check("spur_idle_state", 256'(dbg_state), 256'(0));
    check("spur_idle_res", {bus.res_msb, bus.res_lsb}, last_exp);
    run_job(1'b1, {rand128(), rand128()}, rand128(), rand128(), 14, 1, 4'b0100, 1'b0);
    run_job(1'b0, {rand128(), rand128()}, rand128(), rand128(), 14, 3, 4'b0000, 1'b0);

    // T5 srst in WAIT_L, then a fresh job
    run_job(1'b0, {rand128(), rand128()}, rand128(), rand128(), 8, 1, 4'b1000, 1'b0);
    run_job(1'b1, {rand128(), rand128()}, rand128(), rand128(), 5, 1, 4'b0000, 1'b0);

`ifdef AES_SCHED_TIMEOUT_EN
    // T6 core never answers the MSB issue
    run_job(1'b0, {rand128(), rand128()}, rand128(), rand128(), 14, 1, 4'b0000, 1'b1);
    check("err_sticky", 256'(bus.err), 256'(1));
    core_mute = 1'b0;
    run_job(1'b0, {rand128(), rand128()}, rand128(), rand128(), 6, 1, 4'b0000, 1'b0);
`endif

    // randomized jobs
    for (int j = 0; j < 10; j++) begin
      run_job(1'($urandom_range(0, 1)), {rand128(), rand128()}, rand128(), rand128(),
              $urandom_range(3, 20), $urandom_range(1, 3),
              4'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time got=expired exp=finished");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
